// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined
//   Synchronous-read data memory for the CPU load/store stage. One request per
//   cycle over a valid/ready port, per-lane write strobes, a READ_LATENCY-deep
//   response pipeline, and a zero-fill sweep of the whole array after reset.
//
//   Ports
//     clk, rst_n      clock (posedge) and synchronous active-low reset
//     req_valid       request present
//     req_ready       block can accept (low while the zero-fill sweep runs)
//     req_write       1 = write, 0 = read
//     address         word address
//     write_data      write data
//     write_strobe    lane enables for writes, one bit per LANE_WIDTH slice
//     resp_valid      one pulse per accepted request, READ_LATENCY cycles later
//     resp_is_write   response belongs to a write
//     read_data       read result; 0 for writes, errors and idle cycles
//     addr_error      request address was >= DEPTH

// One byte-lane slice of the array plus its read-data delay line.
//   clk           clock
//   we/addr/wdata write port (shared address with the read port)
//   re            read enable; array is sampled on the same edge
//   rdata         read data, READ_LATENCY edges after re
module dm_lane #(
  parameter int LW           = 8,
  parameter int DEPTH        = 8192,
  parameter int IW           = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [LW-1:0] wdata,
  input  logic          re,
  output logic [LW-1:0] rdata
);

  logic [LW-1:0] mem [DEPTH];
  logic [LW-1:0] rd_q;

  // No reset on the array: the post-reset sweep is the only initialiser.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rd_q <= mem[addr];
  end

  // rd_q is stage 1; dl[k] holds stage k+1. Stale contents are harmless,
  // the top level masks read_data with the matching response flags.
  if (READ_LATENCY == 1) begin : g_l1
    assign rdata = rd_q;
  end else begin : g_dl
    logic [READ_LATENCY-1:1][LW-1:0] dl;
    always_ff @(posedge clk) begin
      dl[1] <= rd_q;
      for (int k = 2; k < READ_LATENCY; k++) dl[k] <= dl[k-1];
    end
    assign rdata = dl[READ_LATENCY-1];
  end

endmodule

module data_memory_pipelined #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATABUS_SIZE   = 24,
  parameter int LANE_WIDTH     = 8,
  parameter int DEPTH          = 8192,
  parameter int READ_LATENCY   = 1,
  localparam int LANES         = DATABUS_SIZE / LANE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_BUS_WIDTH-1:0] address,
  input  logic [DATABUS_SIZE-1:0]   write_data,
  input  logic [LANES-1:0]          write_strobe,
  output logic                      resp_valid,
  output logic                      resp_is_write,
  output logic [DATABUS_SIZE-1:0]   read_data,
  output logic                      addr_error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {INIT, READY} state_t;

  state_t  state, state_nxt;
  logic [IW-1:0] init_ptr;
  logic          init_we;
  logic          accept, in_range, wr_acc, rd_acc;
  logic [IW-1:0] mem_addr;

  logic [LANES-1:0]                 lane_we;
  logic [LANES-1:0][LANE_WIDTH-1:0] lane_wdata;
  logic [LANES-1:0][LANE_WIDTH-1:0] lane_rdata;

  logic [READ_LATENCY:1] vld_pipe, wr_pipe, err_pipe;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (init_we) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_ptr == IW'(DEPTH - 1)) state_nxt = READY;
  end

  always_comb begin
    req_ready = (state == READY);
    init_we   = (state == INIT);
  end

  // ---------------------------------------------------------- request decode
  // Full-width compare: out-of-range addresses must never alias into the
  // array through the truncated index below.
  assign in_range = (32'(address) < DEPTH);
  assign accept   = req_valid & req_ready;
  assign wr_acc   = accept & req_write & in_range;
  assign rd_acc   = accept & ~req_write & in_range;

  // Single address port: the sweep owns it in INIT, requests own it in READY.
  assign mem_addr = init_we ? init_ptr : address[IW-1:0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane_ctl
    assign lane_we[i]    = init_we | (wr_acc & write_strobe[i]);
    assign lane_wdata[i] = init_we ? '0 : write_data[i*LANE_WIDTH +: LANE_WIDTH];
  end

  dm_lane #(
    .LW          (LANE_WIDTH),
    .DEPTH       (DEPTH),
    .IW          (IW),
    .READ_LATENCY(READ_LATENCY)
  ) u_lane [LANES-1:0] (
    .clk  (clk),
    .we   (lane_we),
    .addr (mem_addr),
    .wdata(lane_wdata),
    .re   (rd_acc),
    .rdata(lane_rdata)
  );

  // ------------------------------------------------------ response pipeline
  // Reset clears every stage, which is what drops in-flight responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      wr_pipe  <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      wr_pipe[1]  <= accept & req_write;
      err_pipe[1] <= accept & ~in_range;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        wr_pipe[k]  <= wr_pipe[k-1];
        err_pipe[k] <= err_pipe[k-1];
      end
    end
  end

  assign resp_valid    = vld_pipe[READ_LATENCY];
  assign resp_is_write = wr_pipe[READ_LATENCY];
  assign addr_error    = err_pipe[READ_LATENCY];

  // Lane data is only meaningful for a good read; the select is always a
  // known value, so read_data is 0 (never X) whenever no read is due.
  assign read_data = (vld_pipe[READ_LATENCY] & ~wr_pipe[READ_LATENCY] &
                      ~err_pipe[READ_LATENCY]) ? lane_rdata : '0;

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined. Three instances:
//   u0: 5-bit address, DEPTH 16, latency 1
//   u1: 4-bit address, DEPTH 12, latency 3
//   u2: 5-bit address, DEPTH 16, latency 2
// A queue-based model predicts every output cycle; directed literals pin it.
module tb_data_memory_pipelined;

  function automatic int dep(int d);
    return (d == 1) ? 12 : 16;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        req_valid [3];
  logic        req_write [3];
  logic [4:0]  addr [3];
  logic [23:0] wdata [3];
  logic [2:0]  strb [3];
  logic        ready [3];
  logic        rv [3];
  logic        rw [3];
  logic        aerr [3];
  logic [23:0] rd [3];

  data_memory_pipelined #(.ADDR_BUS_WIDTH(5), .DATABUS_SIZE(24), .LANE_WIDTH(8),
                          .DEPTH(16), .READ_LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(ready[0]),
    .req_write(req_write[0]), .address(addr[0]), .write_data(wdata[0]),
    .write_strobe(strb[0]), .resp_valid(rv[0]), .resp_is_write(rw[0]),
    .read_data(rd[0]), .addr_error(aerr[0]));

  data_memory_pipelined #(.ADDR_BUS_WIDTH(4), .DATABUS_SIZE(24), .LANE_WIDTH(8),
                          .DEPTH(12), .READ_LATENCY(3)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(ready[1]),
    .req_write(req_write[1]), .address(addr[1][3:0]), .write_data(wdata[1]),
    .write_strobe(strb[1]), .resp_valid(rv[1]), .resp_is_write(rw[1]),
    .read_data(rd[1]), .addr_error(aerr[1]));

  data_memory_pipelined #(.ADDR_BUS_WIDTH(5), .DATABUS_SIZE(24), .LANE_WIDTH(8),
                          .DEPTH(16), .READ_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(ready[2]),
    .req_write(req_write[2]), .address(addr[2]), .write_data(wdata[2]),
    .write_strobe(strb[2]), .resp_valid(rv[2]), .resp_is_write(rw[2]),
    .read_data(rd[2]), .addr_error(aerr[2]));

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // ------------------------------------------------------------ model
  typedef struct {
    int          due;
    logic        w;
    logic        e;
    logic [23:0] data;
  } rsp_t;

  rsp_t        q [3][$];
  logic [23:0] mm [3][32];
  int          init_left [3];
  bit          started [3] = '{0, 0, 0};
  int          cyc = 0;
  logic        e_v [3], e_w [3], e_e [3], e_rdy [3];
  logic [23:0] e_d [3];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      e_v[d] = 1'b0; e_w[d] = 1'b0; e_e[d] = 1'b0; e_d[d] = '0;
      if (!rst_n[d]) begin
        started[d]   = 1'b1;
        init_left[d] = dep(d);
        q[d].delete();
      end else if (started[d]) begin
        if (init_left[d] > 0) begin
          init_left[d]--;
          if (init_left[d] == 0)
            for (int a = 0; a < 32; a++) mm[d][a] = '0;
        end else if (req_valid[d]) begin
          rsp_t r;
          int   a;
          a      = int'(addr[d]);
          r.w    = req_write[d];
          r.e    = (a >= dep(d));
          r.due  = cyc + lat(d) - 1;
          r.data = '0;
          if (r.w && !r.e)
            for (int l = 0; l < 3; l++)
              if (strb[d][l]) mm[d][a][l*8 +: 8] = wdata[d][l*8 +: 8];
          if (!r.w && !r.e) r.data = mm[d][a];
          q[d].push_back(r);
        end
        if (q[d].size() > 0 && q[d][0].due == cyc) begin
          rsp_t r2;
          r2 = q[d].pop_front();
          e_v[d] = 1'b1; e_w[d] = r2.w; e_e[d] = r2.e; e_d[d] = r2.data;
        end
      end
      e_rdy[d] = (init_left[d] == 0);
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (started[d])
        chk($sformatf("cycle%0d_dut%0d", cyc, d),
            {ready[d], rv[d], rw[d], aerr[d], rd[d]},
            {e_rdy[d], e_v[d], e_w[d], e_e[d], e_d[d]});
  end

  // ------------------------------------------------------------ stimulus
  task automatic send(int d, logic w, logic [4:0] a, logic [23:0] dat, logic [2:0] s);
    req_valid[d] = 1'b1; req_write[d] = w; addr[d] = a; wdata[d] = dat; strb[d] = s;
    @(negedge clk);
  endtask

  task automatic idle(int d);
    req_valid[d] = 1'b0; req_write[d] = 1'b0; addr[d] = '0; wdata[d] = '0; strb[d] = '0;
  endtask

  task automatic lit_resp(string nm, int d, logic w, logic e, logic [23:0] dat);
    chk(nm, {rv[d], rw[d], aerr[d], rd[d]}, {1'b1, w, e, dat});
  endtask

  // Counts cycles with req_ready low over a fixed 40-cycle window.
  task automatic count_init(int d, output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready[d] !== 1'b1) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt [3];
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      idle(d);
    end
    repeat (3) @(negedge clk);
    chk("rst_outputs_d0", {ready[0], rv[0], rw[0], aerr[0], rd[0]}, 0);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // zero-fill sweep length, all three instances together
    cnt = '{0, 0, 0};
    for (int c = 0; c < 30; c++) begin
      for (int d = 0; d < 3; d++) if (ready[d] !== 1'b1) cnt[d]++;
      @(negedge clk);
    end
    chk("init_len_d0", cnt[0], 16);
    chk("init_len_d1", cnt[1], 12);
    chk("init_len_d2", cnt[2], 16);

    // every word reads back zero after the sweep
    for (int a = 0; a < 16; a++) begin
      send(0, 1'b0, a[4:0], '0, '0);
      lit_resp($sformatf("zero_rd%0d", a), 0, 1'b0, 1'b0, 24'h0);
    end

    // write then read-after-write, then strobe merges
    send(0, 1'b1, 5'd5, 24'hABCDEF, 3'b111);
    lit_resp("wr5_resp", 0, 1'b1, 1'b0, 24'h0);
    send(0, 1'b0, 5'd5, '0, '0);
    lit_resp("raw_5", 0, 1'b0, 1'b0, 24'hABCDEF);
    send(0, 1'b1, 5'd5, 24'h123456, 3'b010);
    send(0, 1'b0, 5'd5, '0, '0);
    lit_resp("strb010", 0, 1'b0, 1'b0, 24'hAB34EF);
    send(0, 1'b1, 5'd5, 24'hFFFFFF, 3'b000);
    send(0, 1'b0, 5'd5, '0, '0);
    lit_resp("strb000", 0, 1'b0, 1'b0, 24'hAB34EF);
    send(0, 1'b1, 5'd5, 24'h111111, 3'b001);
    send(0, 1'b0, 5'd5, '0, '0);
    lit_resp("strb001", 0, 1'b0, 1'b0, 24'hAB3411);

    // out of range on the 16-deep instance; 20 would alias to 4 if truncated
    send(0, 1'b1, 5'd20, 24'h555555, 3'b111);
    lit_resp("oor_wr_d0", 0, 1'b1, 1'b1, 24'h0);
    send(0, 1'b0, 5'd20, '0, '0);
    lit_resp("oor_rd_d0", 0, 1'b0, 1'b1, 24'h0);
    send(0, 1'b0, 5'd4, '0, '0);
    lit_resp("alias4_d0", 0, 1'b0, 1'b0, 24'h0);
    send(0, 1'b0, 5'd15, '0, '0);
    lit_resp("last_ok_d0", 0, 1'b0, 1'b0, 24'h0);
    send(0, 1'b0, 5'd16, '0, '0);
    lit_resp("first_oor_d0", 0, 1'b0, 1'b1, 24'h0);
    idle(0);
    @(negedge clk);
    chk("idle_d0", {rv[0], rd[0]}, 0);

    // latency 3: back-to-back reads come out in order with no gaps
    send(1, 1'b1, 5'd1, 24'h111111, 3'b111);
    send(1, 1'b1, 5'd2, 24'h222222, 3'b111);
    send(1, 1'b1, 5'd3, 24'h333333, 3'b111);
    idle(1);
    repeat (3) @(negedge clk);
    send(1, 1'b0, 5'd1, '0, '0);
    chk("l3_early", rv[1], 0);
    send(1, 1'b0, 5'd2, '0, '0);
    send(1, 1'b0, 5'd3, '0, '0);
    idle(1);
    lit_resp("l3_r1", 1, 1'b0, 1'b0, 24'h111111);
    @(negedge clk);
    lit_resp("l3_r2", 1, 1'b0, 1'b0, 24'h222222);
    @(negedge clk);
    lit_resp("l3_r3", 1, 1'b0, 1'b0, 24'h333333);
    @(negedge clk);
    chk("l3_gap", rv[1], 0);

    // 12-deep instance: address 13 never touches the array
    send(1, 1'b1, 5'd13, 24'hDEAD00, 3'b111);
    send(1, 1'b0, 5'd13, '0, '0);
    send(1, 1'b0, 5'd1, '0, '0);
    idle(1);
    lit_resp("oor13_wr", 1, 1'b1, 1'b1, 24'h0);
    @(negedge clk);
    lit_resp("oor13_rd", 1, 1'b0, 1'b1, 24'h0);
    @(negedge clk);
    lit_resp("a1_intact", 1, 1'b0, 1'b0, 24'h111111);
    send(1, 1'b0, 5'd12, '0, '0);
    send(1, 1'b0, 5'd11, '0, '0);
    idle(1);
    @(negedge clk);
    lit_resp("addr12_err", 1, 1'b0, 1'b1, 24'h0);
    @(negedge clk);
    lit_resp("addr11_ok", 1, 1'b0, 1'b0, 24'h0);

    // latency 2: reset drops an in-flight read and re-zeroes the array
    send(2, 1'b1, 5'd7, 24'h777777, 3'b111);
    send(2, 1'b0, 5'd7, '0, '0);
    lit_resp("l2_wr", 2, 1'b1, 1'b0, 24'h0);
    idle(2);
    @(negedge clk);
    lit_resp("l2_rd7", 2, 1'b0, 1'b0, 24'h777777);
    send(2, 1'b0, 5'd7, '0, '0);
    idle(2);
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("rst_drop_a", {rv[2], rd[2]}, 0);
    @(negedge clk);
    chk("rst_drop_b", {rv[2], ready[2]}, 0);
    rst_n[2] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n[2] = 1'b0;          // reset again part-way through the sweep
    @(negedge clk);
    rst_n[2] = 1'b1;
    count_init(2, cnt[2]);
    chk("reinit_len_d2", cnt[2], 16);
    send(2, 1'b0, 5'd7, '0, '0);
    idle(2);
    @(negedge clk);
    lit_resp("rst_zero7", 2, 1'b0, 1'b0, 24'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
